vga_capture_axis: RTL and testbench

//  Captures raw parallel video (RGB888 + vsync/hsync/blank, one pixel per clock) and
//  re-emits it as a 32-bit AXI4-Stream video master: tuser = start of frame, tlast = end of line.
//  It is the receive-side counterpart of vga_interface. A camera or loopback VGA source feeds
//  its inputs; a frame processor or a video sink feeds from its m_axis port. The source cannot
//  be stalled, so an internal FIFO absorbs m_axis_tready gaps.

---
 rtl/vid_pkg.sv | 18 +
 rtl/vga_capture_fifo.sv | 43 ++++
 rtl/vga_capture_axis.sv | 169 ++++++++++++++++
 tb/tb_vga_capture_axis.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video definitions: capture FSM encoding and the 32-bit AXIS pixel packing.
package vid_pkg;

  typedef enum logic [1:0] {
    WAIT_VSYNC  = 2'd0,
    WAIT_ACTIVE = 2'd1,
    CAPTURE     = 2'd2
  } vid_state_e;

  localparam int         PIX_W   = 32;
  localparam logic [7:0] PIX_PAD = 8'h00;

  function automatic logic [PIX_W-1:0] pack_pix(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
    return {PIX_PAD, r, g, b};
  endfunction

endpackage

// File: rtl/vga_capture_fifo.sv
// Generic synchronous first-word fall-through FIFO; head entry is always on rd_data_o.
module vga_capture_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/vga_capture_axis.sv
// Parallel RGB888 video capture re-emitted as an AXI4-Stream master (tuser = SOF, tlast = EOL).
module vga_capture_axis
  import vid_pkg::*;
#(
  parameter int image_width = 604,
  parameter int image_heigh = 413,
  parameter int FIFO_DEPTH  = 16,
  parameter bit VSYNC_POL   = 1'b0,
  parameter bit HSYNC_POL   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  vid_r_i,
  input  logic [7:0]  vid_g_i,
  input  logic [7:0]  vid_b_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        vid_blank_i,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        overflow_o,
  output logic        frame_err_o
);

  localparam int XW = (image_width > 1) ? $clog2(image_width) : 1;
  localparam int YW = (image_heigh > 1) ? $clog2(image_heigh) : 1;
  localparam int FW = PIX_W + 2;
  localparam logic [XW-1:0] X_LAST = XW'(image_width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(image_heigh - 1);

  logic [7:0] r_q, g_q, b_q;
  logic       vs_q, vs_p_q, hs_q, bl_q, bl_p_q;

  vid_state_e    st_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          sof_q, ovf_q, ferr_q;

  logic          vs_act, vs_act_p, vs_on, vs_off, bl_fall, bl_rise;
  logic          pix_ok, fifo_rd, fifo_full, fifo_empty, wr_en, drop;
  logic [FW-1:0] wr_word, rd_word;
  logic          unused_hs;

  // Sync/blank registers reset to their inactive levels so reset itself creates no edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      vs_q   <= ~VSYNC_POL;
      vs_p_q <= ~VSYNC_POL;
      hs_q   <= ~HSYNC_POL;
      bl_q   <= 1'b1;
      bl_p_q <= 1'b1;
    end else begin
      r_q    <= vid_r_i;
      g_q    <= vid_g_i;
      b_q    <= vid_b_i;
      vs_q   <= vsync_i;
      vs_p_q <= vs_q;
      hs_q   <= hsync_i;
      bl_q   <= vid_blank_i;
      bl_p_q <= bl_q;
    end
  end

  // Line framing comes from blank alone; hsync is kept registered for debug visibility.
  assign unused_hs = (hs_q == HSYNC_POL);

  assign vs_act   = (vs_q == VSYNC_POL);
  assign vs_act_p = (vs_p_q == VSYNC_POL);
  assign vs_on    = vs_act & ~vs_act_p;
  assign vs_off   = ~vs_act & vs_act_p;
  assign bl_fall  = ~bl_q & bl_p_q;
  assign bl_rise  = bl_q & ~bl_p_q;

  // The first active pixel is taken in the same cycle the blank falling edge is seen.
  assign pix_ok  = ~bl_q & ~vs_on &
                   ((st_q == CAPTURE) | ((st_q == WAIT_ACTIVE) & bl_fall));
  assign fifo_rd = m_axis_tvalid & m_axis_tready;
  assign wr_en   = pix_ok & (~fifo_full | fifo_rd);
  assign drop    = pix_ok & fifo_full & ~fifo_rd;
  assign wr_word = {sof_q, (x_q == X_LAST), pack_pix(r_q, g_q, b_q)};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= WAIT_VSYNC;
      x_q    <= '0;
      y_q    <= '0;
      sof_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else if (vs_on) begin
      if ((x_q != '0) || (y_q != '0)) ferr_q <= 1'b1;
      st_q  <= WAIT_ACTIVE;
      x_q   <= '0;
      y_q   <= '0;
      sof_q <= 1'b1;
    end else if (drop) begin
      ovf_q <= 1'b1;
      st_q  <= WAIT_VSYNC;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      case (st_q)
        WAIT_VSYNC: begin
          if (vs_off) begin
            st_q  <= WAIT_ACTIVE;
            x_q   <= '0;
            y_q   <= '0;
            sof_q <= 1'b1;
          end
        end
        WAIT_ACTIVE, CAPTURE: begin
          if (wr_en) begin
            sof_q <= 1'b0;
            if (x_q == X_LAST) begin
              // Leaving CAPTURE here is what drops any surplus active pixels on the line.
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q  <= '0;
                st_q <= WAIT_VSYNC;
              end else begin
                y_q  <= y_q + 1'b1;
                st_q <= WAIT_ACTIVE;
              end
            end else begin
              x_q  <= x_q + 1'b1;
              st_q <= CAPTURE;
            end
          end else if ((st_q == CAPTURE) && bl_rise) begin
            if (x_q != '0) begin
              ferr_q <= 1'b1;
              st_q   <= WAIT_VSYNC;
              x_q    <= '0;
              y_q    <= '0;
            end else begin
              st_q <= WAIT_ACTIVE;
            end
          end
        end
        default: st_q <= WAIT_VSYNC;
      endcase
    end
  end

  vga_capture_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_word),
    .rd_en_i   (fifo_rd),
    .rd_data_o (rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? rd_word : '0;
  assign overflow_o    = ovf_q;
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_vga_capture_axis.sv
// Bench for vga_capture_axis: frame-level vector table plus scoreboard of expected AXIS beats.
module tb_vga_capture_axis;

  localparam int W = 4, H = 3, D = 8;
  localparam int OFF = 0, ON = 1, TOG = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  vr = '0, vg = '0, vb = '0;
  logic        vs = 1'b1, hs = 1'b1, bl = 1'b1, trdy = 1'b0;
  logic        tvalid, tlast, tuser, ovf, ferr;
  logic [31:0] tdata;

  always #5 clk = ~clk;

  vga_capture_axis #(
    .image_width (W), .image_heigh (H), .FIFO_DEPTH (D),
    .VSYNC_POL (1'b0), .HSYNC_POL (1'b0)
  ) dut (
    .clk_i (clk), .rst_i (rst_i),
    .vid_r_i (vr), .vid_g_i (vg), .vid_b_i (vb),
    .vsync_i (vs), .hsync_i (hs), .vid_blank_i (bl),
    .m_axis_tready (trdy), .m_axis_tvalid (tvalid), .m_axis_tdata (tdata),
    .m_axis_tlast (tlast), .m_axis_tuser (tuser),
    .overflow_o (ovf), .frame_err_o (ferr)
  );

  typedef struct {
    string name;
    int    l0, l1, l2;
    int    rdy;
    int    emit;
    bit    ovf;
    bit    ferr;
  } vec_t;

  vec_t        vecs[5];
  int          n_chk = 0, n_pass = 0;
  int          mode = ON, exp_beat = 0, max_emit = 0, fid = 1;
  logic [33:0] q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic vid(input logic b_v, input logic vs_v, input logic hs_v,
                     input logic [7:0] r_v, input logic [7:0] g_v, input logic [7:0] bb_v);
    bl = b_v; vs = vs_v; hs = hs_v; vr = r_v; vg = g_v; vb = bb_v;
    case (mode)
      OFF:     trdy = 1'b0;
      ON:      trdy = 1'b1;
      default: trdy = ~trdy;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle();
    vid(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pix(input int y, input int p);
    logic [7:0] r_v, g_v, b_v;
    r_v = fid[7:0];
    g_v = 8'(y * 16 + p);
    b_v = 8'(p) ^ 8'h5A;
    if (p < W && exp_beat < max_emit) begin
      q.push_back({(p == 0 && y == 0), (p == W - 1), 8'h00, r_v, g_v, b_v});
      exp_beat++;
    end
    vid(1'b0, 1'b1, 1'b1, r_v, g_v, b_v);
  endtask

  task automatic do_line(input int y, input int n);
    vid(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(); idle();
    for (int p = 0; p < n; p++) pix(y, p);
    idle();
  endtask

  task automatic frame_head();
    repeat (2) vid(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    idle(); idle();
  endtask

  task automatic do_frame(input int l0, input int l1, input int l2);
    frame_head();
    do_line(0, l0);
    do_line(1, l1);
    do_line(2, l2);
    repeat (3) idle();
    fid++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle(); idle();
    rst_i = 1'b0;
    q.delete();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    mode = ON;
    while ((q.size() != 0 || tvalid) && n < 300) begin
      idle();
      n++;
    end
    repeat (4) idle();
    check({nm, "_left"}, q.size(), 0);
  endtask

  // Monitor: pop/compare on handshake, and check payload holds while stalled.
  initial begin
    logic        pv, pr;
    logic [33:0] pw, w, e;
    pv = 1'b0; pr = 1'b0; pw = '0;
    forever begin
      @(negedge clk);
      w = {tuser, tlast, tdata};
      if (rst_i) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) check("hold", {tvalid, w}, {1'b1, pw});
        if (tvalid && trdy) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL beat: got unexpected %h want none", w);
          end else begin
            e = q.pop_front();
            check("beat", w, e);
          end
        end
        pv = tvalid; pr = trdy; pw = w;
      end
    end
  end

  initial begin
    vecs[0] = '{"clean",  4, 4, 4, ON,  12, 1'b0, 1'b0};
    vecs[1] = '{"toggle", 4, 4, 4, TOG, 12, 1'b0, 1'b0};
    vecs[2] = '{"stall",  4, 4, 4, OFF,  8, 1'b1, 1'b0};
    vecs[3] = '{"short",  4, 2, 4, ON,   6, 1'b0, 1'b1};
    vecs[4] = '{"long",   6, 4, 4, ON,  12, 1'b0, 1'b0};

    for (int i = 0; i < 5; i++) begin
      mode = ON;
      do_reset();
      check({vecs[i].name, "_rst"}, {tvalid, tlast, tuser, ovf, ferr, tdata}, '0);
      max_emit = vecs[i].emit; exp_beat = 0; mode = vecs[i].rdy;
      do_frame(vecs[i].l0, vecs[i].l1, vecs[i].l2);
      drain(vecs[i].name);
      check({vecs[i].name, "_ovf"},  ovf,  vecs[i].ovf);
      check({vecs[i].name, "_ferr"}, ferr, vecs[i].ferr);
      // Next frame without reset must come through whole, starting with tuser.
      max_emit = 12; exp_beat = 0; mode = ON;
      do_frame(4, 4, 4);
      drain({vecs[i].name, "_next"});
      check({vecs[i].name, "_next_ovf"},  ovf,  vecs[i].ovf);
      check({vecs[i].name, "_next_ferr"}, ferr, vecs[i].ferr);
    end

    // Reset pulse in the middle of line 1 while output is stalled.
    mode = ON;
    do_reset();
    max_emit = 0; exp_beat = 0; mode = OFF;
    frame_head();
    do_line(0, 4);
    vid(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(); idle();
    pix(1, 0); pix(1, 1);
    rst_i = 1'b1;
    pix(1, 2);
    rst_i = 1'b0;
    check("midrst_out", {tvalid, tlast, tuser, ovf, ferr, tdata}, '0);
    mode = ON;
    pix(1, 3);
    idle();
    do_line(2, 4);
    repeat (3) idle();
    fid++;
    check("midrst_quiet", tvalid, 1'b0);
    max_emit = 12; exp_beat = 0;
    do_frame(4, 4, 4);
    drain("midrst_next");
    check("midrst_ovf",  ovf,  1'b0);
    check("midrst_ferr", ferr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
